// File: rtl/unit_output_recv.sv
// unit_output_recv
//   Receiving end of a computing unit's output stream. Requests one packet,
//   waits for the 2'b11 header, deserializes OUT_N_WORDS 2-bit words into
//   16-bit words held in a local BRAM, then presents the packet to the
//   arbiter side through a first-word-fall-through empty/rd_en port.
//
// Ports
//   clk, reset   : single clock, synchronous active-high reset
//   unit_empty   : unit has no packet ready when 1
//   unit_rd_en   : one-cycle request to the unit to start streaming
//   unit_din     : serial data from the unit (idle 0)
//   dout         : current packet word, valid when empty=0
//   rd_en        : consumer read strobe
//   empty        : no word available
//   pkt_end      : dout holds the last word of the packet
//   err_timeout  : sticky, header did not arrive in time
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | local buffer empty, request the next packet when ready
// WAIT_HDR | request sent, waiting up to TIMEOUT cycles for the header
// RECV     | deserializing data words into the BRAM, unit cannot stall
// OUTPUT   | presenting the stored packet to the consumer

module unit_output_recv #(
  parameter int UNIT_OUTPUT_WIDTH = 2,
  parameter int OUT_N_WORDS       = 256 + 32,
  parameter int N_OUT_WORDS16     = OUT_N_WORDS / 8,
  parameter int TIMEOUT           = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         unit_empty,
  output logic                         unit_rd_en,
  input  logic [UNIT_OUTPUT_WIDTH-1:0] unit_din,
  output logic [15:0]                  dout,
  input  logic                         rd_en,
  output logic                         empty,
  output logic                         pkt_end,
  output logic                         err_timeout
);

  if (OUT_N_WORDS % 8 != 0) begin : g_bad_words
    $error("unit_output_recv: OUT_N_WORDS must be a multiple of 8");
  end
  if (UNIT_OUTPUT_WIDTH != 2) begin : g_bad_width
    $error("unit_output_recv: only UNIT_OUTPUT_WIDTH=2 is supported");
  end

  localparam int AW = (N_OUT_WORDS16 > 1) ? $clog2(N_OUT_WORDS16) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_HDR = 2'd1,
    RECV     = 2'd2,
    OUTPUT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [15:0]     sreg_q, sreg_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic            valid_q, valid_d;
  logic            unit_rd_en_q, unit_rd_en_d;
  logic            err_q, err_d;
  logic [15:0]     dout_q;
  logic            mem_we;
  logic            rd_fetch;

  logic [15:0] mem [N_OUT_WORDS16];

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bcnt_d       = bcnt_q;
    wcnt_d       = wcnt_q;
    sreg_d       = sreg_q;
    rptr_d       = rptr_q;
    valid_d      = valid_q;
    unit_rd_en_d = 1'b0;
    err_d        = err_q;
    mem_we       = 1'b0;
    rd_fetch     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!unit_empty) begin
          unit_rd_en_d = 1'b1;
          timer_d      = '0;
          state_d      = WAIT_HDR;
        end
      end
      WAIT_HDR: begin
        // A header on the final allowed cycle still wins over the timeout.
        if (unit_din == 2'b11) begin
          bcnt_d  = '0;
          wcnt_d  = '0;
          state_d = RECV;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RECV: begin
        // Stale bits from the previous group are overwritten before use,
        // so the shift register never needs clearing.
        sreg_d[2*bcnt_q +: 2] = unit_din;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == 3'd7) begin
          mem_we = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == AW'(N_OUT_WORDS16 - 1)) begin
            rptr_d  = '0;
            valid_d = 1'b0;
            state_d = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        // dout is refetched after every accepted read, so empty drops for
        // one cycle between words and a stale word is never shown as valid.
        if (!valid_q) begin
          rd_fetch = 1'b1;
          valid_d  = 1'b1;
        end else if (rd_en) begin
          valid_d = 1'b0;
          if (rptr_q == AW'(N_OUT_WORDS16 - 1)) begin
            state_d = IDLE;
          end else begin
            rptr_d = rptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bcnt_q       <= '0;
      wcnt_q       <= '0;
      sreg_q       <= '0;
      rptr_q       <= '0;
      valid_q      <= 1'b0;
      unit_rd_en_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bcnt_q       <= bcnt_d;
      wcnt_q       <= wcnt_d;
      sreg_q       <= sreg_d;
      rptr_q       <= rptr_d;
      valid_q      <= valid_d;
      unit_rd_en_q <= unit_rd_en_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wcnt_q] <= sreg_d;
    end
  end

  // Registered BRAM read port doubles as the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else if (rd_fetch) begin
      dout_q <= mem[rptr_q];
    end
  end

  assign unit_rd_en  = unit_rd_en_q;
  assign dout        = dout_q;
  assign empty       = !valid_q;
  assign pkt_end     = valid_q && (rptr_q == AW'(N_OUT_WORDS16 - 1));
  assign err_timeout = err_q;

endmodule

// File: tb/tb_unit_output_recv.sv
module tb_unit_output_recv;

  localparam int NW  = 288;
  localparam int N16 = 36;

  logic        clk = 1'b0;
  logic        reset;
  logic        unit_empty;
  logic        unit_rd_en;
  logic [1:0]  unit_din;
  logic [15:0] dout;
  logic        rd_en;
  logic        empty;
  logic        pkt_end;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  logic [1:0]  pat [NW];
  logic [15:0] exp16 [N16];

  unit_output_recv dut (
    .clk        (clk),
    .reset      (reset),
    .unit_empty (unit_empty),
    .unit_rd_en (unit_rd_en),
    .unit_din   (unit_din),
    .dout       (dout),
    .rd_en      (rd_en),
    .empty      (empty),
    .pkt_end    (pkt_end),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic random_pattern;
    for (int i = 0; i < NW; i++) pat[i] = 2'($urandom_range(0, 3));
    for (int g = 0; g < N16; g++)
      for (int k = 0; k < 8; k++) exp16[g][2*k +: 2] = pat[8*g + k];
  endtask

  // Raise unit_empty=0 and wait for the request pulse.
  task automatic request(input bit hold);
    bit ok;
    ok = 1'b0;
    unit_empty = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (unit_rd_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!hold) unit_empty = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL request: unit_rd_en never pulsed, got %b expected 1", unit_rd_en);
    end
  endtask

  // Zeros for 'delay' cycles, header, then the first 'nwords' pattern words.
  task automatic stream(input int delay, input int nwords);
    bit first;
    first = 1'b1;
    for (int i = 0; i < delay; i++) begin
      unit_din = 2'b00;
      tick();
      if (first) begin
        first = 1'b0;
        checks++;
        if (unit_rd_en !== 1'b0) begin
          errors++;
          $display("FAIL rd_en_pulse_width: unit_rd_en=%b expected 0", unit_rd_en);
        end
      end
    end
    unit_din = 2'b11;
    tick();
    if (first) begin
      checks++;
      if (unit_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL rd_en_pulse_width: unit_rd_en=%b expected 0", unit_rd_en);
      end
    end
    for (int i = 0; i < nwords; i++) begin
      unit_din = pat[i];
      tick();
    end
    unit_din = 2'b00;
  endtask

  // Read the whole packet with rd_en asserted 'duty' percent of cycles.
  task automatic drain(input int duty);
    int idx, cyc, wait0;
    bit r;
    idx = 0; cyc = 0; wait0 = 0;
    while (idx < N16 && cyc < 2000) begin
      if (empty === 1'b0) begin
        if (idx == 0 && wait0 >= 0) begin
          checks++;
          if (wait0 > 2) begin
            errors++;
            $display("FAIL first_word_latency: %0d cycles expected <=2", wait0);
          end
          wait0 = -1;
        end
        checks++;
        if (dout !== exp16[idx]) begin
          errors++;
          $display("FAIL dout[%0d]: got %h expected %h", idx, dout, exp16[idx]);
        end
        checks++;
        if (pkt_end !== (idx == N16 - 1)) begin
          errors++;
          $display("FAIL pkt_end[%0d]: got %b expected %b", idx, pkt_end, idx == N16 - 1);
        end
      end else if (idx == 0 && wait0 >= 0) begin
        wait0++;
      end
      checks++;
      if (unit_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL no_rerequest: unit_rd_en=%b during readout expected 0", unit_rd_en);
      end
      r = ($urandom_range(0, 99) < duty);
      rd_en = r;
      if (r && empty === 1'b0) idx++;
      tick();
      cyc++;
    end
    rd_en = 1'b0;
    checks++;
    if (idx != N16) begin
      errors++;
      $display("FAIL drain_timeout: read %0d words expected %0d", idx, N16);
    end
    checks++;
    if (empty !== 1'b1 || pkt_end !== 1'b0) begin
      errors++;
      $display("FAIL after_drain: empty=%b pkt_end=%b expected 1 0", empty, pkt_end);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (unit_rd_en !== 1'b0 || empty !== 1'b1 || pkt_end !== 1'b0 ||
        err_timeout !== 1'b0 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values: rd=%b empty=%b end=%b err=%b dout=%h expected 0 1 0 0 0000",
               unit_rd_en, empty, pkt_end, err_timeout, dout);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (unit_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_request: unit_rd_en=%b expected 0", unit_rd_en);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < NW; i++) pat[i] = 2'(i);
    for (int g = 0; g < N16; g++) exp16[g] = 16'hE4E4;
    request(1'b0);
    stream(0, NW);
    drain(100);
  endtask

  task automatic test_bit_order;
    random_pattern();
    pat[0] = 2'd1;
    for (int k = 1; k < 7; k++) pat[k] = 2'd0;
    pat[7] = 2'd3;
    exp16[0] = 16'hC001;
    request(1'b0);
    stream(0, NW);
    drain(100);
  endtask

  task automatic test_header_delay;
    random_pattern();
    request(1'b0);
    stream(10, NW);
    drain(100);
  endtask

  task automatic test_timeout;
    int n;
    request(1'b0);
    unit_din = 2'b00;
    n = 0;
    while (err_timeout !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL timeout_cycles: err after %0d cycles expected 64", n);
    end
    random_pattern();
    request(1'b0);
    stream(3, NW);
    drain(100);
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err_timeout=%b expected 1", err_timeout);
    end
  endtask

  task automatic test_backpressure;
    random_pattern();
    request(1'b1);
    stream(2, NW);
    drain(30);
    tick();
    checks++;
    if (unit_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL rerequest_after_drain: unit_rd_en=%b expected 1", unit_rd_en);
    end
    unit_empty = 1'b1;
  endtask

  task automatic test_reset_mid_recv;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    random_pattern();
    request(1'b0);
    stream(0, 100);
    reset = 1'b1;
    tick();
    checks++;
    if (empty !== 1'b1 || unit_rd_en !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_recv: empty=%b rd=%b err=%b expected 1 0 0",
               empty, unit_rd_en, err_timeout);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard: empty=%b expected 1", empty);
    end
    random_pattern();
    request(1'b0);
    stream(1, NW);
    drain(60);
  endtask

  initial begin
    reset      = 1'b1;
    unit_empty = 1'b1;
    unit_din   = 2'b00;
    rd_en      = 1'b0;
    test_reset();
    test_basic();
    test_bit_order();
    test_header_delay();
    test_timeout();
    test_backpressure();
    test_reset_mid_recv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
